// File: rtl/alarm_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : alarm_ctrl_if
//  Description : Signal bundle between the alarm scheduler and the rest of
//                the digital clock. It carries the running time, the
//                debounced button pulses, and the alarm state and display
//                controls.
//                master : drives time/buttons, observes alarm outputs
//                slave  : alarm_ctrl side
//  Ports (slave view):
//    in  tick_1hz, cur_hh[8], cur_mm[8], cur_ss[8], clk_set_en,
//        btn_alm_p, btn_sel_p, btn_inc_p, btn_snz_p
//    out alm_hh[8], alm_mm[8], alm_en, alm_edit, blink_sel[2], ring, buzz_out
//  Revision    : 1.0  initial release
// ============================================================================
interface alarm_ctrl_if;
    logic       tick_1hz;
    logic [7:0] cur_hh;
    logic [7:0] cur_mm;
    logic [7:0] cur_ss;
    logic       clk_set_en;
    logic       btn_alm_p;
    logic       btn_sel_p;
    logic       btn_inc_p;
    logic       btn_snz_p;
    logic [7:0] alm_hh;
    logic [7:0] alm_mm;
    logic       alm_en;
    logic       alm_edit;
    logic [1:0] blink_sel;
    logic       ring;
    logic       buzz_out;

    modport master (
        output tick_1hz, cur_hh, cur_mm, cur_ss, clk_set_en,
               btn_alm_p, btn_sel_p, btn_inc_p, btn_snz_p,
        input  alm_hh, alm_mm, alm_en, alm_edit, blink_sel, ring, buzz_out
    );

    modport slave (
        input  tick_1hz, cur_hh, cur_mm, cur_ss, clk_set_en,
               btn_alm_p, btn_sel_p, btn_inc_p, btn_snz_p,
        output alm_hh, alm_mm, alm_en, alm_edit, blink_sel, ring, buzz_out
    );
endinterface
`default_nettype wire

// File: rtl/alarm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : alarm_ctrl
//  Description : Alarm scheduler. Holds a BCD HH:MM alarm time and edits it
//                from button pulses. It compares that time against the
//                running clock and sequences ring / snooze / auto-stop. It
//                also drives the buzzer and the alarm-edit blink select.
//  Ports:
//    clk_50mhz  in   system clock
//    rst        in   synchronous active-high reset
//    bus        slave modport of alarm_ctrl_if (time, buttons, alarm outputs)
//  Revision    : 1.0  initial release
// ============================================================================
module alarm_ctrl #(
    parameter int         RING_SEC   = 60,
    parameter int         SNOOZE_MIN = 5,
    parameter logic [7:0] RST_HH     = 8'h07,
    parameter logic [7:0] RST_MM     = 8'h00
) (
    input  wire logic     clk_50mhz,
    input  wire logic     rst,
    alarm_ctrl_if.slave   bus
);

    localparam int         RING_W   = $clog2(RING_SEC + 1);
    localparam int         SNZ_LOAD = SNOOZE_MIN * 60;
    localparam int         SNZ_W    = $clog2(SNZ_LOAD + 1);
    localparam logic [1:0] c_blink_hh   = 2'b00;
    localparam logic [1:0] c_blink_mm   = 2'b01;
    localparam logic [1:0] c_blink_none = 2'b11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        EDIT_HH = 3'd1,
        EDIT_MM = 3'd2,
        RING    = 3'd3,
        SNOOZE  = 3'd4
    } state_t;

    state_t              r_state, w_state_nx;
    logic [7:0]          r_hh, w_hh_nx;
    logic [7:0]          r_mm, w_mm_nx;
    logic                r_en, w_en_nx;
    logic [RING_W-1:0]   r_ring_cnt, w_ring_cnt_nx, w_ring_inc;
    logic [SNZ_W-1:0]    r_snz_cnt, w_snz_cnt_nx, w_snz_dec;
    logic                r_beep, w_beep_nx;
    logic                r_match_q;
    logic                w_match, w_trigger;
    logic                r_edit, w_edit_nx;
    logic [1:0]          r_blink, w_blink_nx;
    logic                r_ring, w_ring_nx;
    logic                r_buzz, w_buzz_nx;

    // Per-nibble BCD increment that wraps to 00 once the field reaches max.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        if (v == max)
            return 8'h00;
        else if (v[3:0] == 4'h9)
            return {v[7:4] + 4'h1, 4'h0};
        else
            return {v[7:4], v[3:0] + 4'h1};
    endfunction

    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            r_state    <= IDLE;
            r_hh       <= RST_HH;
            r_mm       <= RST_MM;
            r_en       <= 1'b0;
            r_ring_cnt <= '0;
            r_snz_cnt  <= '0;
            r_beep     <= 1'b0;
            r_match_q  <= 1'b0;
            r_edit     <= 1'b0;
            r_blink    <= c_blink_none;
            r_ring     <= 1'b0;
            r_buzz     <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_hh       <= w_hh_nx;
            r_mm       <= w_mm_nx;
            r_en       <= w_en_nx;
            r_ring_cnt <= w_ring_cnt_nx;
            r_snz_cnt  <= w_snz_cnt_nx;
            r_beep     <= w_beep_nx;
            r_match_q  <= w_match;
            r_edit     <= w_edit_nx;
            r_blink    <= w_blink_nx;
            r_ring     <= w_ring_nx;
            r_buzz     <= w_buzz_nx;
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_hh_nx       = r_hh;
        w_mm_nx       = r_mm;
        w_en_nx       = r_en;
        w_ring_cnt_nx = r_ring_cnt;
        w_snz_cnt_nx  = r_snz_cnt;
        w_beep_nx     = r_beep;
        w_ring_inc    = r_ring_cnt + 1'b1;
        w_snz_dec     = r_snz_cnt - 1'b1;

        // Edge-detect the match so one alarm minute rings only once.
        w_match   = r_en & ~bus.clk_set_en & (bus.cur_hh == r_hh) &
                    (bus.cur_mm == r_mm) & (bus.cur_ss == 8'h00);
        w_trigger = w_match & ~r_match_q;

        unique case (r_state)
            IDLE: begin
                if (bus.btn_alm_p) begin
                    w_state_nx = EDIT_HH;
                end else if (bus.btn_snz_p) begin
                    w_en_nx = ~r_en;
                end else if (w_trigger) begin
                    w_state_nx    = RING;
                    w_ring_cnt_nx = '0;
                    w_beep_nx     = 1'b1;
                end
            end
            EDIT_HH, EDIT_MM: begin
                if (bus.btn_alm_p) begin
                    w_state_nx = IDLE;
                    w_en_nx    = 1'b1;
                end else if (bus.btn_sel_p) begin
                    w_state_nx = (r_state == EDIT_HH) ? EDIT_MM : EDIT_HH;
                end else if (bus.btn_inc_p) begin
                    if (r_state == EDIT_HH)
                        w_hh_nx = bcd_inc(r_hh, 8'h23);
                    else
                        w_mm_nx = bcd_inc(r_mm, 8'h59);
                end
            end
            RING: begin
                if (bus.btn_alm_p) begin
                    w_state_nx = IDLE;
                end else if (bus.btn_snz_p) begin
                    w_state_nx   = SNOOZE;
                    w_snz_cnt_nx = SNZ_W'(SNZ_LOAD);
                end else if (bus.tick_1hz) begin
                    w_ring_cnt_nx = w_ring_inc;
                    w_beep_nx     = ~r_beep;
                    if (w_ring_inc == RING_W'(RING_SEC))
                        w_state_nx = IDLE;
                end
            end
            SNOOZE: begin
                if (bus.btn_alm_p) begin
                    w_state_nx = IDLE;
                end else if (bus.tick_1hz) begin
                    w_snz_cnt_nx = w_snz_dec;
                    if (w_snz_dec == '0) begin
                        w_state_nx    = RING;
                        w_ring_cnt_nx = '0;
                        w_beep_nx     = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they register in step with it.
        w_ring_nx  = (w_state_nx == RING);
        w_buzz_nx  = w_ring_nx & w_beep_nx;
        w_edit_nx  = (w_state_nx == EDIT_HH) || (w_state_nx == EDIT_MM);
        w_blink_nx = (w_state_nx == EDIT_HH) ? c_blink_hh :
                     (w_state_nx == EDIT_MM) ? c_blink_mm : c_blink_none;
    end

    assign bus.alm_hh    = r_hh;
    assign bus.alm_mm    = r_mm;
    assign bus.alm_en    = r_en;
    assign bus.alm_edit  = r_edit;
    assign bus.blink_sel = r_blink;
    assign bus.ring      = r_ring;
    assign bus.buzz_out  = r_buzz;

endmodule
`default_nettype wire
